// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative, write-back, write-allocate data cache
// that sits between the CPU data port and a single-outstanding memory bus.
// Supports true-LRU replacement, byte/half/word stores, and an uncached bypass.
//
// Ports
//   clk, reset           clock; synchronous active-low reset (0 = reset)
//   cpu_req/wr/size      CPU request, held stable until cpu_data_ok
//   cpu_addr/wdata       byte address and lane-aligned store data
//   cpu_uncached         send this request straight to the bus
//   cpu_addr_ok/data_ok  request accepted / completed (always together)
//   cpu_rdata            load data
//   mem_req/wen/size     bus request, write flag, transfer size
//   mem_addr/wdata       bus address and write data
//   mem_rdata            bus read data
//   mem_addr_ok/data_ok  bus accepted the request / finished the transfer
module dcache_assoc #(
  parameter int WAYS         = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORDS     = 2 ** (OFFSET_WIDTH - 2);
  localparam int SETS      = 2 ** INDEX_WIDTH;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int KW        = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL, UNC} state_t;

  // Way-major storage keeps every reset/fill loop bounded by WAYS or WORDS.
  logic [SETS-1:0]             r_valid [WAYS];
  logic [SETS-1:0]             r_dirty [WAYS];
  logic [SETS-1:0][WAY_W-1:0]  r_age   [WAYS];
  logic [TAG_WIDTH-1:0]        r_tag   [WAYS][SETS];
  logic [31:0]                 r_data  [WAYS][SETS][WORDS];
  logic [31:0]                 r_buf   [WORDS];

  state_t                 r_state, w_nextState;
  logic [KW-1:0]          r_k;
  logic                   r_waitData;
  logic [TAG_WIDTH-1:0]   r_tagReq;
  logic [INDEX_WIDTH-1:0] r_lineIndex;
  logic [WAY_W-1:0]       r_victim;

  logic [TAG_WIDTH-1:0]    w_cpuTag;
  logic [INDEX_WIDTH-1:0]  w_cpuIndex;
  logic [KW-1:0]           w_cpuWord;
  logic [OFFSET_WIDTH-1:0] w_kOffset;
  logic [3:0]              w_be;
  logic [WAYS-1:0]         w_hitVec;
  logic                    w_hitAny;
  logic [WAY_W-1:0]        w_hitWay;
  logic [WAY_W-1:0]        w_victim;
  logic                    w_hit;
  logic                    w_wordDone;
  logic                    w_lastWord;
  logic                    w_fill;
  logic                    w_touch;
  logic [INDEX_WIDTH-1:0]  w_touchSet;
  logic [WAY_W-1:0]        w_touchWay;
  logic [WAY_W-1:0]        w_touchAge;

  assign w_cpuTag   = cpu_addr[31 -: TAG_WIDTH];
  assign w_cpuIndex = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_cpuWord  = (WORDS > 1) ? cpu_addr[2 +: KW] : '0;
  assign w_kOffset  = OFFSET_WIDTH'({r_k, 2'b00});
  assign w_lastWord = (r_k == KW'(WORDS - 1));

  // A bus word completes on data_ok once the address phase is done; an
  // address and data acknowledge arriving together also count as complete.
  assign w_wordDone = reset && (r_state != IDLE) && mem_data_ok && (r_waitData || mem_addr_ok);
  assign w_fill     = (r_state == REFILL) && w_wordDone && w_lastWord;

  assign w_touch    = w_hit || w_fill;
  assign w_touchSet = w_hit ? w_cpuIndex : r_lineIndex;
  assign w_touchWay = w_hit ? w_hitWay : r_victim;
  assign w_touchAge = r_age[w_touchWay][w_touchSet];

  // Byte-lane enables for stores.
  always_comb begin
    w_be = 4'b1111;
    case (cpu_size)
      2'd0:    w_be = 4'b0001 << cpu_addr[1:0];
      2'd1:    w_be = cpu_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Tag lookup and victim choice: lowest invalid way wins, otherwise the
  // oldest way (age == WAYS-1).
  always_comb begin
    w_hitVec = '0;
    w_hitWay = '0;
    w_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hitVec[w] = r_valid[w][w_cpuIndex] && (r_tag[w][w_cpuIndex] == w_cpuTag);
      if (r_age[w][w_cpuIndex] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hitVec[w]) w_hitWay = WAY_W'(w);
      if (!r_valid[w][w_cpuIndex]) w_victim = WAY_W'(w);
    end
    w_hitAny = |w_hitVec;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state and all outputs; everything is held at zero while reset is low.
  always_comb begin
    w_nextState = r_state;
    w_hit       = 1'b0;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_wen     = 1'b0;
    mem_size    = 2'd0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_uncached) begin
              w_nextState = UNC;
            end else if (w_hitAny) begin
              w_hit       = 1'b1;
              cpu_addr_ok = 1'b1;
              cpu_data_ok = 1'b1;
              cpu_rdata   = r_data[w_hitWay][w_cpuIndex][w_cpuWord];
            end else if (r_valid[w_victim][w_cpuIndex] && r_dirty[w_victim][w_cpuIndex]) begin
              w_nextState = WB;
            end else begin
              w_nextState = REFILL;
            end
          end
        end
        WB: begin
          mem_req   = !r_waitData;
          mem_wen   = 1'b1;
          mem_size  = 2'd2;
          mem_addr  = {r_tag[r_victim][r_lineIndex], r_lineIndex, w_kOffset};
          mem_wdata = r_data[r_victim][r_lineIndex][r_k];
          if (w_wordDone && w_lastWord) w_nextState = REFILL;
        end
        REFILL: begin
          mem_req  = !r_waitData;
          mem_size = 2'd2;
          mem_addr = {r_tagReq, r_lineIndex, w_kOffset};
          if (w_fill) w_nextState = IDLE;
        end
        UNC: begin
          mem_req   = !r_waitData;
          mem_wen   = cpu_wr;
          mem_size  = cpu_size;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (w_wordDone) begin
            cpu_addr_ok = 1'b1;
            cpu_data_ok = 1'b1;
            cpu_rdata   = mem_rdata;
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Miss bookkeeping and the per-word bus handshake tracker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k         <= '0;
      r_waitData  <= 1'b0;
      r_tagReq    <= '0;
      r_lineIndex <= '0;
      r_victim    <= '0;
    end else if (r_state == IDLE) begin
      r_k        <= '0;
      r_waitData <= 1'b0;
      if (cpu_req && !cpu_uncached && !w_hitAny) begin
        r_tagReq    <= w_cpuTag;
        r_lineIndex <= w_cpuIndex;
        r_victim    <= w_victim;
      end
    end else if (w_wordDone) begin
      r_waitData <= 1'b0;
      r_k        <= w_lastWord ? '0 : r_k + 1'b1;
    end else if (mem_req && mem_addr_ok) begin
      r_waitData <= 1'b1;
    end
  end

  // Line state and true-LRU ages; the touched way becomes youngest and every
  // way younger than it ages by one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
        r_age[w]   <= {SETS{WAY_W'(w)}};
      end
    end else if (w_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == w_touchWay)
          r_age[w][w_touchSet] <= '0;
        else if (r_age[w][w_touchSet] < w_touchAge)
          r_age[w][w_touchSet] <= r_age[w][w_touchSet] + 1'b1;
      end
      if (w_hit && cpu_wr) r_dirty[w_hitWay][w_cpuIndex] <= 1'b1;
      if (w_fill) begin
        r_valid[r_victim][r_lineIndex] <= 1'b1;
        r_dirty[r_victim][r_lineIndex] <= 1'b0;
        r_tag[r_victim][r_lineIndex]   <= r_tagReq;
      end
    end
  end

  // Data array and refill buffer. The last refill word goes straight from the
  // bus into the array because it has not reached the buffer yet.
  always_ff @(posedge clk) begin
    if (w_hit && cpu_wr) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_data[w_hitWay][w_cpuIndex][w_cpuWord][8*b +: 8] <= cpu_wdata[8*b +: 8];
    end
    if (w_fill) begin
      for (int i = 0; i < WORDS; i++)
        r_data[r_victim][r_lineIndex][i] <= (i == WORDS - 1) ? mem_rdata : r_buf[i];
    end
    if ((r_state == REFILL) && w_wordDone) r_buf[r_k] <= mem_rdata;
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed bench for dcache_assoc (WAYS=2, INDEX_WIDTH=7,
// OFFSET_WIDTH=4). A small bus responder records every accepted transaction;
// unwritten memory words read back as 0xC0DE0000 | addr[15:0].
module tb_dcache_assoc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpuReq = 1'b0;
  logic        cpuWr = 1'b0;
  logic [1:0]  cpuSize = 2'd2;
  logic [31:0] cpuAddr = '0;
  logic [31:0] cpuWdata = '0;
  logic        cpuUnc = 1'b0;
  logic        cpuAddrOk, cpuDataOk;
  logic [31:0] cpuRdata;
  logic        memReq, memWen;
  logic [1:0]  memSize;
  logic [31:0] memAddr, memWdata;
  logic [31:0] memRdata = '0;
  logic        memAddrOk = 1'b0;
  logic        memDataOk = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  logic        fastBus = 1'b0;
  logic        busy = 1'b0;
  logic [31:0] pendAddr = '0;
  logic [31:0] memStore [logic [31:0]];
  logic [31:0] txAddr[$];
  logic [31:0] txData[$];
  logic        txWen[$];
  logic [1:0]  txSize[$];

  dcache_assoc #(.WAYS(2), .INDEX_WIDTH(7), .OFFSET_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_wr(cpuWr), .cpu_size(cpuSize), .cpu_addr(cpuAddr),
    .cpu_wdata(cpuWdata), .cpu_uncached(cpuUnc),
    .cpu_addr_ok(cpuAddrOk), .cpu_data_ok(cpuDataOk), .cpu_rdata(cpuRdata),
    .mem_req(memReq), .mem_wen(memWen), .mem_size(memSize), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata),
    .mem_addr_ok(memAddrOk), .mem_data_ok(memDataOk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memStore.exists(a)) return memStore[a];
    return 32'hC0DE0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic recordTx();
    txAddr.push_back(memAddr);
    txData.push_back(memWdata);
    txWen.push_back(memWen);
    txSize.push_back(memSize);
    if (memWen && memSize == 2'd2) memStore[memAddr] = memWdata;
  endtask

  // Bus responder: normal mode acks the address, then returns data on the
  // following cycle; fast mode acks address and data in the same cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        memAddrOk = 1'b0;
        memDataOk = 1'b0;
        busy = 1'b0;
      end else if (fastBus) begin
        if (memReq) begin
          recordTx();
          memAddrOk = 1'b1;
          memDataOk = 1'b1;
          memRdata = memRead(memAddr);
        end else begin
          memAddrOk = 1'b0;
          memDataOk = 1'b0;
        end
      end else if (busy) begin
        memAddrOk = 1'b0;
        memDataOk = 1'b1;
        memRdata = memRead(pendAddr);
        busy = 1'b0;
      end else begin
        memDataOk = 1'b0;
        if (memReq) begin
          recordTx();
          pendAddr = memAddr;
          memAddrOk = 1'b1;
          busy = 1'b1;
        end else begin
          memAddrOk = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txClear();
    txAddr.delete();
    txData.delete();
    txWen.delete();
    txSize.delete();
  endtask

  // One CPU request; starts just after a rising edge, returns just after the
  // edge that consumes cpu_data_ok. cycles counts sampled cycles up to data_ok.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic unc,
                               output logic [31:0] rdata, output int cycles);
    cpuReq = 1'b1;
    cpuWr = wr;
    cpuSize = size;
    cpuAddr = addr;
    cpuWdata = wdata;
    cpuUnc = unc;
    cycles = 0;
    do begin
      @(negedge clk);
      #1;
      cycles++;
    end while (!cpuDataOk && cycles < 200);
    if (!cpuDataOk) checkOutput("reqTimeout", 32'd0, 32'd1);
    rdata = cpuRdata;
    @(posedge clk);
    #1;
    cpuReq = 1'b0;
  endtask

  task automatic checkTx(input string tag, input int idx, input logic [31:0] addr, input logic wen);
    checkOutput({tag, "Addr"}, (idx < txAddr.size()) ? txAddr[idx] : 32'hFFFFFFFF, addr);
    checkOutput({tag, "Wen"}, (idx < txWen.size()) ? 32'(txWen[idx]) : 32'hFFFFFFFF, 32'(wen));
  endtask

  logic [31:0] rd;
  int cyc;
  int n;

  initial begin
    // Outputs stay low while reset is held, even with a pending request.
    cpuReq = 1'b1; cpuUnc = 1'b1; cpuAddr = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rstMemReq", 32'(memReq), 32'd0);
    checkOutput("rstAddrOk", 32'(cpuAddrOk), 32'd0);
    checkOutput("rstDataOk", 32'(cpuDataOk), 32'd0);
    cpuReq = 1'b0; cpuUnc = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Cold load fills the whole line then hits.
    txClear();
    applyStimulus(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, rd, cyc);
    checkOutput("coldRdata", rd, 32'hC0DE0104);
    checkOutput("coldCycles", 32'(cyc), 32'd10);
    checkOutput("coldNTx", 32'(txAddr.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkTx("cold", i, 32'h100 + 32'(4 * i), 1'b0);

    txClear();
    applyStimulus(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, rd, cyc);
    checkOutput("hitRdata", rd, 32'hC0DE0104);
    checkOutput("hitCycles", 32'(cyc), 32'd1);
    checkOutput("hitNTx", 32'(txAddr.size()), 32'd0);

    // Byte, half and word stores merge into the resident line.
    applyStimulus(1'b1, 2'd0, 32'h105, 32'h0000AB00, 1'b0, rd, cyc);
    checkOutput("stByteCycles", 32'(cyc), 32'd1);
    applyStimulus(1'b1, 2'd1, 32'h10A, 32'h12340000, 1'b0, rd, cyc);
    applyStimulus(1'b1, 2'd2, 32'h10C, 32'hDEADBEEF, 1'b0, rd, cyc);
    applyStimulus(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, rd, cyc);
    checkOutput("stByteRd", rd, 32'hC0DEAB04);
    applyStimulus(1'b0, 2'd2, 32'h108, 32'h0, 1'b0, rd, cyc);
    checkOutput("stHalfRd", rd, 32'h12340108);
    checkOutput("noTxOnStores", 32'(txAddr.size()), 32'd0);

    // Second line in the set goes to the invalid way without a write-back.
    txClear();
    applyStimulus(1'b0, 2'd2, 32'h900, 32'h0, 1'b0, rd, cyc);
    checkOutput("ld900Rd", rd, 32'hC0DE0900);
    checkOutput("ld900Cycles", 32'(cyc), 32'd10);

    // Third line evicts the dirty 0x100 line: four writes, then four reads.
    txClear();
    applyStimulus(1'b0, 2'd2, 32'h1100, 32'h0, 1'b0, rd, cyc);
    checkOutput("evictRd", rd, 32'hC0DE1100);
    checkOutput("evictCycles", 32'(cyc), 32'd18);
    checkOutput("evictNTx", 32'(txAddr.size()), 32'd8);
    for (int i = 0; i < 4; i++) checkTx("wb", i, 32'h100 + 32'(4 * i), 1'b1);
    for (int i = 0; i < 4; i++) checkTx("rf", i + 4, 32'h1100 + 32'(4 * i), 1'b0);
    checkOutput("wbData0", txData.size() > 0 ? txData[0] : 32'hFFFFFFFF, 32'hC0DE0100);
    checkOutput("wbData1", txData.size() > 1 ? txData[1] : 32'hFFFFFFFF, 32'hC0DEAB04);
    checkOutput("wbData2", txData.size() > 2 ? txData[2] : 32'hFFFFFFFF, 32'h12340108);
    checkOutput("wbData3", txData.size() > 3 ? txData[3] : 32'hFFFFFFFF, 32'hDEADBEEF);

    // LRU: fill 0x100 and 0x900, touch 0x100, then 0x1100 must evict 0x900.
    applyStimulus(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, rd, cyc);
    checkOutput("refetchWbRd", rd, 32'hC0DEAB04);
    applyStimulus(1'b0, 2'd2, 32'h900, 32'h0, 1'b0, rd, cyc);
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, rd, cyc);
    checkOutput("lruTouchCycles", 32'(cyc), 32'd1);
    applyStimulus(1'b0, 2'd2, 32'h1100, 32'h0, 1'b0, rd, cyc);
    checkOutput("lruMissCycles", 32'(cyc), 32'd10);
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, rd, cyc);
    checkOutput("lruKeptCycles", 32'(cyc), 32'd1);
    checkOutput("lruKeptRd", rd, 32'hC0DE0100);
    applyStimulus(1'b0, 2'd2, 32'h900, 32'h0, 1'b0, rd, cyc);
    checkOutput("lruEvictedCycles", 32'(cyc), 32'd10);

    // Uncached load and byte store: one bus transfer each, nothing installed.
    txClear();
    applyStimulus(1'b0, 2'd2, 32'hBFC00000, 32'h0, 1'b1, rd, cyc);
    checkOutput("uncRd", rd, 32'hC0DE0000);
    checkOutput("uncCycles", 32'(cyc), 32'd3);
    checkOutput("uncNTx", 32'(txAddr.size()), 32'd1);
    checkTx("unc", 0, 32'hBFC00000, 1'b0);
    checkOutput("uncSize", txSize.size() > 0 ? 32'(txSize[0]) : 32'hFFFFFFFF, 32'd2);
    txClear();
    applyStimulus(1'b1, 2'd0, 32'hBFC00003, 32'h5A000000, 1'b1, rd, cyc);
    checkTx("uncSt", 0, 32'hBFC00003, 1'b1);
    checkOutput("uncStSize", txSize.size() > 0 ? 32'(txSize[0]) : 32'hFFFFFFFF, 32'd0);
    checkOutput("uncStData", txData.size() > 0 ? txData[0] : 32'hFFFFFFFF, 32'h5A000000);
    applyStimulus(1'b0, 2'd2, 32'hBFC00000, 32'h0, 1'b0, rd, cyc);
    checkOutput("uncNotInstalled", 32'(cyc), 32'd10);

    // Address and data acknowledged in the same cycle complete each word.
    fastBus = 1'b1;
    txClear();
    applyStimulus(1'b0, 2'd2, 32'h3204, 32'h0, 1'b0, rd, cyc);
    checkOutput("fastRd", rd, 32'hC0DE3204);
    checkOutput("fastCycles", 32'(cyc), 32'd6);
    checkOutput("fastNTx", 32'(txAddr.size()), 32'd4);
    fastBus = 1'b0;
    @(posedge clk); #1;

    // Reset while the refill is on word 2 aborts the fill.
    txClear();
    cpuReq = 1'b1; cpuWr = 1'b0; cpuSize = 2'd2; cpuAddr = 32'h5100; cpuUnc = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (txAddr.size() < 3 && n < 100);
    checkOutput("rstWord2Seen", 32'(txAddr.size()), 32'd3);
    reset = 1'b0;
    cpuReq = 1'b0;
    #1;
    checkOutput("rstMidMemReq", 32'(memReq), 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("postRstMemReq", 32'(memReq), 32'd0);
    checkOutput("postRstDataOk", 32'(cpuDataOk), 32'd0);
    @(posedge clk); #1;
    txClear();
    applyStimulus(1'b0, 2'd2, 32'h104, 32'h0, 1'b0, rd, cyc);
    checkOutput("postRstMissCycles", 32'(cyc), 32'd10);
    checkOutput("postRstRd", rd, 32'hC0DEAB04);
    checkTx("postRst", 0, 32'h100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
